// File: rtl/virtio_mmio.sv
// rtl/virtio_mmio.sv - Legacy virtio-mmio register block behind an AXI4-Lite slave port.

module virtio_mmio #(
    parameter int unsigned NUM_QUEUES    = 2,
    parameter int unsigned QUEUE_NUM_MAX = 8,
    parameter logic [31:0] DEVICE_ID     = 32'h2,
    parameter logic [31:0] HOST_FEATURES = 32'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [2:0]  axi_arprot,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [2:0]  axi_awprot,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic        irq_used,
    input  logic        irq_config,
    output logic        interrupt,
    output logic        notify_valid,
    output logic [2:0]  notify_queue,
    output logic        dev_reset,
    input  logic [2:0]  cfg_sel,
    output logic [31:0] cfg_pfn,
    output logic [31:0] cfg_num,
    output logic [31:0] guest_page_size,
    output logic [31:0] status
);

    localparam int unsigned NQ = 8;

    localparam logic [5:0] OFF_MAGIC    = 6'h00;
    localparam logic [5:0] OFF_VERSION  = 6'h01;
    localparam logic [5:0] OFF_DEVID    = 6'h02;
    localparam logic [5:0] OFF_VENDOR   = 6'h03;
    localparam logic [5:0] OFF_HFEAT    = 6'h04;
    localparam logic [5:0] OFF_HFSEL    = 6'h05;
    localparam logic [5:0] OFF_GFEAT    = 6'h08;
    localparam logic [5:0] OFF_GFSEL    = 6'h09;
    localparam logic [5:0] OFF_GPSIZE   = 6'h0a;
    localparam logic [5:0] OFF_QSEL     = 6'h0c;
    localparam logic [5:0] OFF_QNUMMAX  = 6'h0d;
    localparam logic [5:0] OFF_QNUM     = 6'h0e;
    localparam logic [5:0] OFF_QALIGN   = 6'h0f;
    localparam logic [5:0] OFF_QPFN     = 6'h10;
    localparam logic [5:0] OFF_QNOTIFY  = 6'h14;
    localparam logic [5:0] OFF_ISR      = 6'h18;
    localparam logic [5:0] OFF_ISRACK   = 6'h19;
    localparam logic [5:0] OFF_STATUS   = 6'h1c;

    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        bvalid_q, bvalid_d;
    logic [5:0]  awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0] host_feat_sel_q, host_feat_sel_d;
    logic [31:0] guest_feat_q, guest_feat_d;
    logic [31:0] guest_feat_sel_q, guest_feat_sel_d;
    logic [31:0] page_size_q, page_size_d;
    logic [31:0] queue_sel_q, queue_sel_d;
    logic [31:0] status_q, status_d;
    logic [31:0] pfn_q [NQ];
    logic [31:0] pfn_d [NQ];
    logic [31:0] num_q [NQ];
    logic [31:0] num_d [NQ];
    logic [31:0] align_q [NQ];
    logic [31:0] align_d [NQ];
    logic [1:0]  isr_q, isr_d;
    logic [1:0]  isr_clr;
    logic        interrupt_q, interrupt_d;
    logic        notify_valid_q, notify_valid_d;
    logic [2:0]  notify_queue_q, notify_queue_d;
    logic        dev_reset_q, dev_reset_d;

    logic        qsel_ok;
    logic [2:0]  qsel_idx;
    logic [31:0] rd_val;
    logic        aw_take, w_take, commit, wr_en;
    logic [5:0]  wr_off;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        cfg_ok;
    logic        unused_bits;

    assign unused_bits = ^{axi_arprot, axi_awprot, axi_araddr[31:8], axi_araddr[1:0],
                           axi_awaddr[31:8], axi_awaddr[1:0]};

    assign qsel_ok  = (queue_sel_q < NUM_QUEUES);
    assign qsel_idx = queue_sel_q[2:0];

    always_comb begin
        rd_val = '0;
        case (axi_araddr[7:2])
            OFF_MAGIC:   rd_val = 32'h7472_6976;
            OFF_VERSION: rd_val = 32'd1;
            OFF_DEVID:   rd_val = DEVICE_ID;
            OFF_VENDOR:  rd_val = 32'h554d_4551;
            OFF_HFEAT:   rd_val = (host_feat_sel_q == '0) ? HOST_FEATURES : '0;
            OFF_QNUMMAX: rd_val = qsel_ok ? QUEUE_NUM_MAX : '0;
            OFF_QPFN:    rd_val = qsel_ok ? pfn_q[qsel_idx] : '0;
            OFF_ISR:     rd_val = {30'd0, isr_q};
            OFF_STATUS:  rd_val = status_q;
            default:     rd_val = '0;
        endcase
    end

    // Single outstanding read: arready drops while a response is pending.
    always_comb begin
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        if (axi_arvalid && arready_q) begin
            arready_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = rd_val;
        end
        if (rvalid_q && axi_rready) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
        end
    end

    // A beat arriving this cycle counts as held, so commit happens in the
    // same cycle as the later of the two handshakes.
    assign aw_take = axi_awvalid && awready_q;
    assign w_take  = axi_wvalid && wready_q;
    assign commit  = (aw_held_q || aw_take) && (w_held_q || w_take);
    assign wr_off  = aw_held_q ? awaddr_q : axi_awaddr[7:2];
    assign wr_data = w_held_q ? wdata_q : axi_wdata;
    assign wr_strb = w_held_q ? wstrb_q : axi_wstrb;
    assign wr_en   = commit && (wr_strb == 4'hF);

    always_comb begin
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        if (aw_take) begin
            awready_d = 1'b0;
            aw_held_d = 1'b1;
        end
        if (w_take) begin
            wready_d = 1'b0;
            w_held_d = 1'b1;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
        end
        if (bvalid_q && axi_bready) begin
            bvalid_d  = 1'b0;
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
    end

    always_comb begin
        host_feat_sel_d  = host_feat_sel_q;
        guest_feat_d     = guest_feat_q;
        guest_feat_sel_d = guest_feat_sel_q;
        page_size_d      = page_size_q;
        queue_sel_d      = queue_sel_q;
        status_d         = status_q;
        pfn_d            = pfn_q;
        num_d            = num_q;
        align_d          = align_q;
        isr_clr          = 2'b00;
        notify_valid_d   = 1'b0;
        notify_queue_d   = notify_queue_q;
        dev_reset_d      = 1'b0;
        if (wr_en) begin
            case (wr_off)
                OFF_HFSEL:  host_feat_sel_d  = wr_data;
                OFF_GFEAT:  guest_feat_d     = wr_data;
                OFF_GFSEL:  guest_feat_sel_d = wr_data;
                OFF_GPSIZE: page_size_d      = wr_data;
                OFF_QSEL:   queue_sel_d      = wr_data;
                OFF_QNUM:   if (qsel_ok) num_d[qsel_idx]   = wr_data;
                OFF_QALIGN: if (qsel_ok) align_d[qsel_idx] = wr_data;
                OFF_QPFN:   if (qsel_ok) pfn_d[qsel_idx]   = wr_data;
                OFF_QNOTIFY: begin
                    if (wr_data < NUM_QUEUES) begin
                        notify_valid_d = 1'b1;
                        notify_queue_d = wr_data[2:0];
                    end
                end
                OFF_ISRACK: isr_clr = wr_data[1:0];
                OFF_STATUS: begin
                    status_d = wr_data;
                    if (wr_data == '0) begin
                        dev_reset_d  = 1'b1;
                        guest_feat_d = '0;
                        queue_sel_d  = '0;
                        isr_clr      = 2'b11;
                        for (int i = 0; i < NQ; i++) begin
                            pfn_d[i]   = '0;
                            num_d[i]   = '0;
                            align_d[i] = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
        // A device event arriving with an ack of the same bit wins.
        isr_d       = (isr_q & ~isr_clr) | {irq_config, irq_used};
        interrupt_d = |isr_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arready_q        <= 1'b1;
            rvalid_q         <= 1'b0;
            rdata_q          <= '0;
            awready_q        <= 1'b1;
            wready_q         <= 1'b1;
            aw_held_q        <= 1'b0;
            w_held_q         <= 1'b0;
            bvalid_q         <= 1'b0;
            awaddr_q         <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            host_feat_sel_q  <= '0;
            guest_feat_q     <= '0;
            guest_feat_sel_q <= '0;
            page_size_q      <= 32'h1000;
            queue_sel_q      <= '0;
            status_q         <= '0;
            for (int i = 0; i < NQ; i++) begin
                pfn_q[i]   <= '0;
                num_q[i]   <= '0;
                align_q[i] <= '0;
            end
            isr_q            <= 2'b00;
            interrupt_q      <= 1'b0;
            notify_valid_q   <= 1'b0;
            notify_queue_q   <= 3'd0;
            dev_reset_q      <= 1'b0;
        end else begin
            arready_q        <= arready_d;
            rvalid_q         <= rvalid_d;
            rdata_q          <= rdata_d;
            awready_q        <= awready_d;
            wready_q         <= wready_d;
            aw_held_q        <= aw_held_d;
            w_held_q         <= w_held_d;
            bvalid_q         <= bvalid_d;
            if (aw_take) awaddr_q <= axi_awaddr[7:2];
            if (w_take) begin
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
            end
            host_feat_sel_q  <= host_feat_sel_d;
            guest_feat_q     <= guest_feat_d;
            guest_feat_sel_q <= guest_feat_sel_d;
            page_size_q      <= page_size_d;
            queue_sel_q      <= queue_sel_d;
            status_q         <= status_d;
            pfn_q            <= pfn_d;
            num_q            <= num_d;
            align_q          <= align_d;
            isr_q            <= isr_d;
            interrupt_q      <= interrupt_d;
            notify_valid_q   <= notify_valid_d;
            notify_queue_q   <= notify_queue_d;
            dev_reset_q      <= dev_reset_d;
        end
    end

    assign cfg_ok = ({29'd0, cfg_sel} < NUM_QUEUES);
    assign cfg_pfn = cfg_ok ? pfn_q[cfg_sel] : '0;
    assign cfg_num = cfg_ok ? num_q[cfg_sel] : '0;

    assign axi_arready     = arready_q;
    assign axi_rvalid      = rvalid_q;
    assign axi_rdata       = rdata_q;
    assign axi_rresp       = 2'b00;
    assign axi_awready     = awready_q;
    assign axi_wready      = wready_q;
    assign axi_bvalid      = bvalid_q;
    assign axi_bresp       = 2'b00;
    assign interrupt       = interrupt_q;
    assign notify_valid    = notify_valid_q;
    assign notify_queue    = notify_queue_q;
    assign dev_reset       = dev_reset_q;
    assign guest_page_size = page_size_q;
    assign status          = status_q;

endmodule

// File: tb/tb_virtio_mmio.sv
// tb/tb_virtio_mmio.sv - Directed-vector bench for virtio_mmio.

module tb_virtio_mmio;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] axi_araddr = '0;
    logic        axi_arvalid = 1'b0;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready = 1'b0;
    logic [31:0] axi_awaddr = '0;
    logic        axi_awvalid = 1'b0;
    logic        axi_awready;
    logic [31:0] axi_wdata = '0;
    logic [3:0]  axi_wstrb = 4'hF;
    logic        axi_wvalid = 1'b0;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready = 1'b1;
    logic        irq_used = 1'b0;
    logic        irq_config = 1'b0;
    logic        interrupt;
    logic        notify_valid;
    logic [2:0]  notify_queue;
    logic        dev_reset;
    logic [2:0]  cfg_sel = 3'd0;
    logic [31:0] cfg_pfn;
    logic [31:0] cfg_num;
    logic [31:0] guest_page_size;
    logic [31:0] status;

    int n_vec  = 0;
    int n_miss = 0;
    int n_notify = 0;
    int n_devrst = 0;
    logic [2:0] notify_seen = '0;

    always #5 clk = ~clk;

    virtio_mmio #(.HOST_FEATURES(32'h1234_5678)) dut (
        .clk(clk), .rstn(rstn),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(3'b000),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(3'b000),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .irq_used(irq_used), .irq_config(irq_config), .interrupt(interrupt),
        .notify_valid(notify_valid), .notify_queue(notify_queue), .dev_reset(dev_reset),
        .cfg_sel(cfg_sel), .cfg_pfn(cfg_pfn), .cfg_num(cfg_num),
        .guest_page_size(guest_page_size), .status(status)
    );

    always @(negedge clk) begin
        if (notify_valid) begin
            n_notify++;
            notify_seen = notify_queue;
        end
        if (dev_reset) n_devrst++;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int t;
        @(negedge clk);
        axi_araddr  = addr;
        axi_arvalid = 1'b1;
        axi_rready  = 1'b1;
        t = 0;
        while (!axi_arready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) check_vec("ar_timeout", 32'd1, 32'd0);
        @(negedge clk);
        axi_arvalid = 1'b0;
        t = 0;
        while (!axi_rvalid && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) check_vec("r_timeout", 32'd1, 32'd0);
        data = axi_rdata;
        @(negedge clk);
        axi_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        int t;
        logic aw_go, w_go;
        @(negedge clk);
        axi_awaddr  = addr;
        axi_awvalid = 1'b1;
        axi_wdata   = data;
        axi_wstrb   = strb;
        axi_wvalid  = 1'b1;
        t = 0;
        while ((axi_awvalid || axi_wvalid) && t < 20) begin
            aw_go = axi_awvalid && axi_awready;
            w_go  = axi_wvalid && axi_wready;
            @(negedge clk);
            if (aw_go) axi_awvalid = 1'b0;
            if (w_go) axi_wvalid = 1'b0;
            t++;
        end
        if (t >= 20) check_vec("aw_w_timeout", 32'd1, 32'd0);
        t = 0;
        while (!axi_bvalid && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) check_vec("b_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check_vec(tag, d, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;

        repeat (3) @(negedge clk);
        check_vec("rst_arready", {31'd0, axi_arready}, 32'd1);
        check_vec("rst_awready", {31'd0, axi_awready}, 32'd1);
        check_vec("rst_wready", {31'd0, axi_wready}, 32'd1);
        check_vec("rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
        check_vec("rst_bvalid", {31'd0, axi_bvalid}, 32'd0);
        check_vec("rst_irq", {31'd0, interrupt}, 32'd0);
        check_vec("rst_pagesize", guest_page_size, 32'h1000);
        check_vec("rst_status", status, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // identification registers and address aliasing
        rd_check("magic", 32'h00, 32'h7472_6976);
        check_vec("rresp", {30'd0, axi_rresp}, 32'd0);
        rd_check("version", 32'h04, 32'd1);
        rd_check("devid", 32'h08, 32'd2);
        rd_check("vendor", 32'h0c, 32'h554d_4551);
        rd_check("magic_alias_hi", 32'h100, 32'h7472_6976);
        rd_check("magic_alias_lo", 32'h03, 32'h7472_6976);
        rd_check("hostfeat0", 32'h10, 32'h1234_5678);
        axi_write(32'h14, 32'd1, 4'hF);
        rd_check("hostfeat1", 32'h10, 32'd0);
        axi_write(32'h14, 32'd0, 4'hF);
        rd_check("unmapped", 32'h44, 32'd0);

        // queue select, QueueNumMax and PFN
        axi_write(32'h30, 32'd1, 4'hF);
        rd_check("qnummax_q1", 32'h34, 32'd8);
        axi_write(32'h40, 32'h80, 4'hF);
        axi_write(32'h30, 32'd0, 4'hF);
        rd_check("pfn_q0", 32'h40, 32'd0);
        cfg_sel = 3'd1; #1;
        check_vec("cfg_pfn_1", cfg_pfn, 32'h80);
        axi_write(32'h38, 32'd16, 4'hF);
        cfg_sel = 3'd0; #1;
        check_vec("cfg_num_0", cfg_num, 32'd16);
        check_vec("cfg_pfn_0", cfg_pfn, 32'd0);
        axi_write(32'h30, 32'd3, 4'hF);
        rd_check("qnummax_oor", 32'h34, 32'd0);
        axi_write(32'h40, 32'h99, 4'hF);
        rd_check("pfn_oor", 32'h40, 32'd0);
        cfg_sel = 3'd5; #1;
        check_vec("cfg_pfn_oor", cfg_pfn, 32'd0);
        cfg_sel = 3'd1; #1;
        check_vec("cfg_pfn_kept", cfg_pfn, 32'h80);
        axi_write(32'h30, 32'd1, 4'hF);
        axi_write(32'h40, 32'h55, 4'h7);
        #1;
        check_vec("partial_strobe", cfg_pfn, 32'h80);

        // W beat three cycles ahead of AW
        @(negedge clk);
        axi_wdata = 32'hA5; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        @(negedge clk);
        axi_wvalid = 1'b0;
        check_vec("skew_wready_low", {31'd0, axi_wready}, 32'd0);
        check_vec("skew_b_early1", {31'd0, axi_bvalid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        axi_awaddr = 32'h70; axi_awvalid = 1'b1;
        check_vec("skew_b_early2", {31'd0, axi_bvalid}, 32'd0);
        @(negedge clk);
        axi_awvalid = 1'b0;
        check_vec("skew_bvalid", {31'd0, axi_bvalid}, 32'd1);
        check_vec("skew_awready_low", {31'd0, axi_awready}, 32'd0);
        @(negedge clk);
        check_vec("skew_b_once", {31'd0, axi_bvalid}, 32'd0);
        check_vec("skew_readies", {30'd0, axi_awready, axi_wready}, 32'd3);
        check_vec("skew_status", status, 32'hA5);
        rd_check("skew_rd_status", 32'h70, 32'hA5);

        // read response held while rready is low
        @(negedge clk);
        axi_araddr = 32'h0c; axi_arvalid = 1'b1; axi_rready = 1'b0;
        @(negedge clk);
        axi_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("hold_rvalid", {31'd0, axi_rvalid}, 32'd1);
        check_vec("hold_rdata", axi_rdata, 32'h554d_4551);
        check_vec("hold_arready", {31'd0, axi_arready}, 32'd0);
        axi_rready = 1'b1;
        @(negedge clk);
        axi_rready = 1'b0;
        check_vec("hold_done", {30'd0, axi_rvalid, axi_arready}, 32'd1);

        // queue notify
        base = n_notify;
        axi_write(32'h50, 32'd1, 4'hF);
        repeat (2) @(negedge clk);
        check_vec("notify_cnt", n_notify - base, 32'd1);
        check_vec("notify_q", {29'd0, notify_seen}, 32'd1);
        base = n_notify;
        axi_write(32'h50, 32'd5, 4'hF);
        repeat (2) @(negedge clk);
        check_vec("notify_oor", n_notify - base, 32'd0);
        base = n_notify;
        axi_write(32'h50, 32'd0, 4'hF);
        repeat (2) @(negedge clk);
        check_vec("notify_q0_cnt", n_notify - base, 32'd1);
        check_vec("notify_q0", {29'd0, notify_seen}, 32'd0);

        // interrupt status set, ack and same-cycle collision
        @(negedge clk);
        irq_used = 1'b1;
        @(negedge clk);
        irq_used = 1'b0;
        check_vec("irq_set", {31'd0, interrupt}, 32'd1);
        rd_check("isr_used", 32'h60, 32'd1);
        @(negedge clk);
        axi_awaddr = 32'h64; axi_awvalid = 1'b1;
        axi_wdata = 32'd1; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        irq_used = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; irq_used = 1'b0;
        check_vec("ack_collide_b", {31'd0, axi_bvalid}, 32'd1);
        check_vec("ack_collide_irq", {31'd0, interrupt}, 32'd1);
        @(negedge clk);
        rd_check("isr_after_collide", 32'h60, 32'd1);
        axi_write(32'h64, 32'd1, 4'hF);
        check_vec("ack_clear_irq", {31'd0, interrupt}, 32'd0);
        rd_check("isr_cleared", 32'h60, 32'd0);
        @(negedge clk);
        irq_config = 1'b1;
        @(negedge clk);
        irq_config = 1'b0;
        rd_check("isr_config", 32'h60, 32'd2);
        axi_write(32'h64, 32'd1, 4'hF);
        check_vec("ack_wrong_bit", {31'd0, interrupt}, 32'd1);

        // device reset through Status=0
        base = n_devrst;
        axi_write(32'h70, 32'hF, 4'hF);
        rd_check("status_f", 32'h70, 32'hF);
        axi_write(32'h28, 32'h2000, 4'hF);
        axi_write(32'h30, 32'd3, 4'hF);
        check_vec("no_devrst_nonzero", n_devrst - base, 32'd0);
        axi_write(32'h70, 32'd0, 4'hF);
        @(negedge clk);
        check_vec("devrst_cnt", n_devrst - base, 32'd1);
        rd_check("status_0", 32'h70, 32'd0);
        rd_check("qsel_cleared", 32'h34, 32'd8);
        rd_check("pfn_cleared", 32'h40, 32'd0);
        rd_check("isr_reset", 32'h60, 32'd0);
        check_vec("irq_reset", {31'd0, interrupt}, 32'd0);
        cfg_sel = 3'd1; #1;
        check_vec("cfg_pfn_reset", cfg_pfn, 32'd0);
        cfg_sel = 3'd0; #1;
        check_vec("cfg_num_reset", cfg_num, 32'd0);
        check_vec("pagesize_kept", guest_page_size, 32'h2000);

        // reset asserted while a read response and a lone W beat are pending
        @(negedge clk);
        axi_araddr = 32'h0; axi_arvalid = 1'b1; axi_rready = 1'b0;
        axi_wdata = 32'h77; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0; axi_wvalid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check_vec("async_rst_rvalid", {31'd0, axi_rvalid}, 32'd0);
        check_vec("async_rst_wready", {31'd0, axi_wready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        axi_rready = 1'b1;
        base = 0;
        repeat (4) begin
            @(negedge clk);
            if (axi_rvalid || axi_bvalid) base++;
        end
        axi_rready = 1'b0;
        check_vec("abort_no_resp", base, 32'd0);
        check_vec("rst_pagesize2", guest_page_size, 32'h1000);
        axi_write(32'h70, 32'h3, 4'hF);
        rd_check("post_rst_write", 32'h70, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
